// File: rtl/pixel_stream_pkg.sv
// pixel_stream_pkg: shared types for the pixel stream source.
//   state_e : reader FSM encoding (IDLE, STREAM, DRAIN, DONE)
//   PIX_W   : pixel width in bits
//   flags_t : per-pixel markers {sof, eol, eof}
//   beat_t  : one stream beat, pixel plus its markers
package pixel_stream_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } flags_t;

    typedef struct packed {
        logic [PIX_W-1:0] pix;
        flags_t           flags;
    } beat_t;

endpackage

// File: rtl/pixel_skid_buf.sv
// pixel_skid_buf: 2-entry valid/ready buffer for {pixel, flags}.
// When empty, an arriving beat is presented combinationally (fall-through),
// so RAM data reaches the stream the same cycle it returns.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   in_valid_i    : beat arriving this cycle (cannot be stalled)
//   in_data_i     : arriving beat
//   out_valid_o   : stream valid
//   out_ready_i   : stream ready
//   out_data_o    : stream beat, all zero when out_valid_o is low
//   occ_o         : number of stored entries (0..2)
module pixel_skid_buf
    import pixel_stream_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid_i,
    input  beat_t      in_data_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output beat_t      out_data_o,
    output logic [1:0] occ_o
);

    beat_t      mem_q [2];
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] cnt_q;
    logic       stored, pop, push, pop_st;

    assign stored      = (cnt_q != 2'd0);
    assign out_valid_o = stored | in_valid_i;
    assign out_data_o  = stored ? mem_q[rd_ptr_q] : (in_valid_i ? in_data_i : '0);
    assign pop         = out_valid_o & out_ready_i;
    // An arriving beat is stored unless it goes straight through an empty buffer.
    assign push        = in_valid_i & ~(~stored & out_ready_i);
    assign pop_st      = pop & stored;
    assign occ_o       = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push)   wr_ptr_q <= ~wr_ptr_q;
            if (pop_st) rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop_st})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end

endmodule

// File: rtl/pixel_stream_src.sv
// pixel_stream_src: reads an IMG_W x IMG_H frame in raster order from a
// synchronous-read RAM and emits it as a valid/ready pixel stream with
// sof/eol/eof markers, then pulses frame_done.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   start            : one-cycle frame request (honoured only when idle)
//   busy             : frame in progress
//   mem_rd_en/addr   : RAM read strobe / raster address
//   mem_rdata        : RAM data, valid the cycle after mem_rd_en
//   pixel_*          : output stream (valid/ready, sof/eol/eof)
//   frame_done       : one-cycle pulse after the eof transfer
// Build option: PIXEL_SRC_HBLANK_EN inserts H_BLANK idle cycles after each
// line's eol transfer (none after eof).
module pixel_stream_src
    import pixel_stream_pkg::*;
#(
    parameter int IMG_W   = 256,
    parameter int IMG_H   = 256,
    parameter int ADDR_W  = 16,
    parameter int H_BLANK = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              pixel_valid,
    input  logic              pixel_ready,
    output logic              pixel_sof,
    output logic              pixel_eol,
    output logic              pixel_eof,
    output logic              frame_done
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

`ifdef PIXEL_SRC_HBLANK_EN
    localparam bit BLANK_BUILD = 1'b1;
`else
    localparam bit BLANK_BUILD = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic              pend_q;      // read issued last cycle, data on mem_rdata now
    flags_t            pend_fl_q;   // markers of that in-flight read
    flags_t            rd_fl;
    beat_t             in_beat, out_beat;
    logic [1:0]        occ;
    logic [2:0]        lvl;
    logic              out_valid, pop, rd_allow, rd_go;

    // Markers of the address about to be read.
    assign rd_fl.sof = (x_q == '0) && (y_q == '0);
    assign rd_fl.eol = (x_q == X_LAST);
    assign rd_fl.eof = rd_fl.eol && (y_q == Y_LAST);

    assign pop = out_valid & pixel_ready;
    // Stored + in-flight after this cycle's transfer; a new read must keep it <= 2.
    assign lvl   = {1'b0, occ} + {2'b00, pend_q} - {2'b00, pop};
    assign rd_go = (state_q == ST_STREAM) && (lvl < 3'd2) && rd_allow;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                    addr_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            ST_STREAM: begin
                if (rd_go) begin
                    if (rd_fl.eof) begin
                        state_d = ST_DRAIN;   // address stays on the last one read
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (rd_fl.eol) begin
                            x_d = '0;
                            y_d = y_q + YW'(1);
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && out_beat.flags.eof) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            pend_q    <= 1'b0;
            pend_fl_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pend_q  <= rd_go;
            if (rd_go) pend_fl_q <= rd_fl;
        end
    end

    generate
        if (BLANK_BUILD && (H_BLANK > 0)) begin : g_blank
            localparam int CW = $clog2(H_BLANK + 1);
            logic          blk_q, run_q;
            logic [CW-1:0] cnt_q;
            logic          go;

            // Reads stay blocked from a line's last read until the counter,
            // started at that line's eol transfer, reaches its final cycle.
            assign go       = run_q && (cnt_q == CW'(1));
            assign rd_allow = ~blk_q | go;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    blk_q <= 1'b0;
                    run_q <= 1'b0;
                    cnt_q <= '0;
                end else begin
                    if (rd_go) blk_q <= rd_fl.eol & ~rd_fl.eof;
                    if (rd_go) begin
                        run_q <= 1'b0;
                    end else if (blk_q && !run_q && pop && out_beat.flags.eol) begin
                        run_q <= 1'b1;
                        cnt_q <= CW'(H_BLANK);
                    end else if (run_q && cnt_q != CW'(1)) begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
            end
        end else begin : g_noblank
            assign rd_allow = 1'b1;
        end
    endgenerate

    assign in_beat.pix   = mem_rdata;
    assign in_beat.flags = pend_fl_q;

    pixel_skid_buf u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (pend_q),
        .in_data_i   (in_beat),
        .out_valid_o (out_valid),
        .out_ready_i (pixel_ready),
        .out_data_o  (out_beat),
        .occ_o       (occ)
    );

    assign busy        = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
    assign frame_done  = (state_q == ST_DONE);
    assign mem_rd_en   = rd_go;
    assign mem_addr    = addr_q;
    assign pixel_valid = out_valid;
    assign pixel_out   = out_beat.pix;
    assign pixel_sof   = out_beat.flags.sof;
    assign pixel_eol   = out_beat.flags.eol;
    assign pixel_eof   = out_beat.flags.eof;

endmodule

// File: tb/tb_pixel_stream_src.sv
// Directed bench for pixel_stream_src on a 4x4 ramp frame (mem[i] = i).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_pixel_stream_src;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = W * H;
    localparam int AW = 16;
    localparam int HB = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pixel_ready = 1'b1;
    logic          busy, mem_rd_en, pixel_valid, pixel_sof, pixel_eol, pixel_eof, frame_done;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata = 8'h00;
    logic [7:0]    pixel_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Ramp frame RAM with synchronous read.
    always @(posedge clk) if (mem_rd_en) mem_rdata <= 8'(mem_addr);

    pixel_stream_src #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .H_BLANK(HB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .pixel_sof   (pixel_sof),
        .pixel_eol   (pixel_eol),
        .pixel_eof   (pixel_eof),
        .frame_done  (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ready held high; checks raster order from index n0 up to frame_done.
    task automatic run_collect(input string tag, input int n0);
        int n;
        bit done;
        n = n0;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            pixel_ready = 1'b1;
            #1;
            if (pixel_valid && pixel_ready) begin
                chk(tag, {24'h0, pixel_out}, n);
                n++;
            end
            if (frame_done) done = 1'b1;
        end
        chk({tag, "_count"}, n, N);
        chk({tag, "_done"}, {31'h0, done}, 1);
    endtask

    initial begin
        int  ntx, nrd, nd;
        bit  done, prev_stall;
        logic [7:0] prev_pix;
        logic [2:0] prev_fl;

        // ---- reset state
        @(negedge clk); #1;
        chk("rst_ctrl", {busy, mem_rd_en, pixel_valid, pixel_sof, pixel_eol, pixel_eof, frame_done}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_pix", pixel_out, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        chk("idle_busy", busy, 0);

`ifndef PIXEL_SRC_HBLANK_EN
        // ---- continuous frame, exact timing
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        chk("t1_busy", busy, 1);
        chk("t1_rd0", mem_rd_en, 1);
        chk("t1_addr0", mem_addr, 0);
        chk("t1_nvalid", pixel_valid, 0);
        for (int i = 0; i < N; i++) begin
            @(negedge clk); #1;
            chk("t1_valid", pixel_valid, 1);
            chk("t1_pix", pixel_out, i);
            chk("t1_flags", {pixel_sof, pixel_eol, pixel_eof},
                {i == 0, (i % W) == W - 1, i == N - 1});
            chk("t1_rd", mem_rd_en, i < N - 1);
            chk("t1_addr", mem_addr, (i < N - 1) ? i + 1 : N - 1);
            chk("t1_fd_low", frame_done, 0);
        end
        @(negedge clk); #1;
        chk("t1_done", frame_done, 1);
        chk("t1_busy_fall", busy, 0);
        chk("t1_valid_fall", pixel_valid, 0);
        @(negedge clk); #1;
        chk("t1_done_pulse", frame_done, 0);
`else
        // ---- horizontal blanking: 3 idle cycles after each non-final eol
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        chk("hb_rd0", mem_rd_en, 1);
        for (int l = 0; l < H; l++) begin
            for (int p = 0; p < W; p++) begin
                @(negedge clk); #1;
                chk("hb_valid", pixel_valid, 1);
                chk("hb_pix", pixel_out, l * W + p);
                chk("hb_eol", pixel_eol, p == W - 1);
            end
            if (l < H - 1) begin
                for (int b = 0; b < HB; b++) begin
                    @(negedge clk); #1;
                    chk("hb_idle", pixel_valid, 0);
                end
            end
        end
        @(negedge clk); #1;
        chk("hb_done", frame_done, 1);
`endif

        // ---- ready toggling 1,0,0: order, no duplicates, stable while stalled
        @(negedge clk); start = 1'b1;
        ntx = 0; done = 1'b0; prev_stall = 1'b0; prev_pix = '0; prev_fl = '0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            start = 1'b0;
            pixel_ready = (c % 3 == 0);
            #1;
            if (prev_stall) begin
                chk("tg_hold_valid", pixel_valid, 1);
                chk("tg_hold_pix", pixel_out, prev_pix);
                chk("tg_hold_flags", {pixel_sof, pixel_eol, pixel_eof}, prev_fl);
            end
            if (pixel_valid && pixel_ready) begin
                chk("tg_order", pixel_out, ntx);
                ntx++;
            end
            prev_stall = pixel_valid && !pixel_ready;
            prev_pix   = pixel_out;
            prev_fl    = {pixel_sof, pixel_eol, pixel_eof};
            if (frame_done) done = 1'b1;
        end
        chk("tg_count", ntx, N);
        chk("tg_done", {31'h0, done}, 1);

        // ---- ready low for 10 cycles after first valid: at most 2 reads
        @(negedge clk); pixel_ready = 1'b0; start = 1'b1;
        nrd = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); start = 1'b0; #1;
            nrd += int'(mem_rd_en);
            if (pixel_valid) begin
                chk("st_pix", pixel_out, 0);
                chk("st_sof", pixel_sof, 1);
            end
        end
        chk("st_reads", nrd, 2);
        chk("st_valid", pixel_valid, 1);
        run_collect("st_resume", 0);

        // ---- start mid-frame and during DONE is ignored
        @(negedge clk); start = 1'b1;
        ntx = 0; nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (pixel_valid && pixel_ready) begin
                chk("ig_order", pixel_out, ntx);
                ntx++;
            end
            if (frame_done) nd++;
            start = (c == 4) || frame_done;
        end
        start = 1'b0;
        chk("ig_frames", nd, 1);
        chk("ig_count", ntx, N);
        chk("ig_busy", busy, 0);

        // ---- reset after the 7th pixel, then a fresh frame
        @(negedge clk); start = 1'b1;
        ntx = 0;
        for (int c = 0; c < 40 && ntx < 7; c++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (pixel_valid && pixel_ready) begin
                chk("rs_pre", pixel_out, ntx);
                ntx++;
            end
        end
        chk("rs_pre_count", ntx, 7);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("rs_ctrl", {busy, mem_rd_en, pixel_valid, pixel_sof, pixel_eol, pixel_eof, frame_done}, 0);
        chk("rs_addr", mem_addr, 0);
        chk("rs_pix", pixel_out, 0);
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rs_idle", {busy, pixel_valid}, 0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        chk("rs_rd0", {mem_rd_en, mem_addr}, {1'b1, 16'h0});
        @(negedge clk); #1;
        chk("rs_first", {pixel_valid, pixel_sof, pixel_out}, {2'b11, 8'h00});
        run_collect("rs_frame", 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
